uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter (`transmit` / `data_tx` / `busy_tx` of the autobaud UART) between up to four byte-stream requesters: the command-response path of the GPIO command parser, plus event reporters. Message-locked round-robin arbitration: once granted, a requester keeps the transmitter until it sends a byte flagged `last`, so multi-byte replies are never interleaved. A lock timeout releases a stalled owner.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter sharing one UART transmitter among NREQ byte
// streams; an owner keeps the lock until its 'last' byte, or until the lock timeout.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd50000,
  parameter logic [3:0]  START_WAIT   = 4'd8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [8*NREQ-1:0] data,
  input  logic              busy_tx,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              transmit,
  output logic [7:0]        data_tx,
  output logic              timeout_err
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitStart, StWaitDone, StHold} state_e;

  localparam logic [15:0] LockLast  = LOCK_TIMEOUT - 16'd1;
  localparam logic [15:0] StartLast = {12'd0, START_WAIT} - 16'd1;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            msg_end_q, msg_end_d;
  logic            tmo_q, tmo_d;
  logic [7:0]      data_tx_q, data_tx_d;

  logic [1:0] owner_nxt, pick, load_idx;
  logic [2:0] cand;
  logic       found, load, done;

  assign owner_nxt = (owner_q == 2'(NREQ - 1)) ? 2'd0 : owner_q + 2'd1;

  // First pending requester at or above ptr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!found && req[cand[1:0]]) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    msg_end_d = msg_end_q;
    data_tx_d = data_tx_q;
    tmo_d     = 1'b0;
    load      = 1'b0;
    load_idx  = owner_q;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!busy_tx && found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          owner_d       = pick;
          load          = 1'b1;
          load_idx      = pick;
        end
      end
      StIssue: begin
        state_d = StWaitStart;
        cnt_d   = '0;
      end
      StWaitStart: begin
        if (busy_tx)                  state_d = StWaitDone;
        else if (cnt_q == StartLast)  done    = 1'b1;
        else                          cnt_d   = cnt_q + 16'd1;
      end
      StWaitDone: begin
        if (!busy_tx) done = 1'b1;
      end
      StHold: begin
        // A pending owner byte wins over a timeout on the same cycle.
        if (req[owner_q]) begin
          if (!busy_tx) load = 1'b1;
        end else if (cnt_q == LockLast) begin
          tmo_d   = 1'b1;
          grant_d = '0;
          ptr_d   = owner_nxt;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      if (msg_end_q) begin
        grant_d = '0;
        ptr_d   = owner_nxt;
        state_d = StIdle;
      end else begin
        state_d = StHold;
        cnt_d   = '0;
      end
    end

    // Byte is captured on the edge into StIssue so data_tx is valid with transmit.
    if (load) begin
      state_d   = StIssue;
      data_tx_d = data[{load_idx, 3'b000} +: 8];
      msg_end_d = last[load_idx];
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      msg_end_q <= 1'b0;
      tmo_q     <= 1'b0;
      data_tx_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      msg_end_q <= msg_end_d;
      tmo_q     <= tmo_d;
      data_tx_q <= data_tx_d;
    end
  end

  assign transmit    = (state_q == StIssue);
  assign ack         = transmit ? grant_q : '0;
  assign grant       = grant_q;
  assign data_tx     = data_tx_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: lane drivers feed byte queues, a monitor
// checks every transmit against the hand-ordered expected queue.
module tb_uart_tx_arbiter;

  localparam int FRAME = 6;

  logic        clk = 1'b0;
  logic        nRst;
  logic [3:0]  req, last;
  logic [31:0] data;
  logic        busy_tx;
  logic [3:0]  ack, grant;
  logic        transmit;
  logic [7:0]  data_tx;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [8:0] stim_q [4][$];
  logic [9:0] exp_q [$];
  logic [9:0] mon_e;
  logic [3:0] ack_s;
  logic       uart_mute = 1'b0;
  int         tmo_at, tmo_cnt, tx_at;

  uart_tx_arbiter #(
    .NREQ        (4),
    .LOCK_TIMEOUT(16'd16),
    .START_WAIT  (4'd8)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .req        (req),
    .last       (last),
    .data       (data),
    .busy_tx    (busy_tx),
    .ack        (ack),
    .grant      (grant),
    .transmit   (transmit),
    .data_tx    (data_tx),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int lane, input logic l, input logic [7:0] b);
    stim_q[lane].push_back({l, b});
  endtask

  task automatic expect_tx(input logic [1:0] lane, input logic [7:0] b);
    exp_q.push_back({lane, b});
  endtask

  task automatic wait_exp(input int n, input string what);
    int k = 0;
    while (exp_q.size() > n && k < 400) begin
      step();
      k++;
    end
    if (exp_q.size() > n) chk({what, "_tx_timeout"}, exp_q.size(), n);
  endtask

  task automatic wait_busy(input logic lvl, input string what);
    int k = 0;
    while (busy_tx !== lvl && k < 100) begin
      step();
      k++;
    end
    if (busy_tx !== lvl) chk({what, "_busy_timeout"}, {31'd0, busy_tx}, {31'd0, lvl});
  endtask

  task automatic drain(input string what);
    wait_exp(0, what);
    wait_busy(1'b1, what);
    wait_busy(1'b0, what);
    step();
  endtask

  // UART model: busy rises the cycle after transmit and stays up for FRAME-1 cycles.
  initial begin
    busy_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (transmit && !uart_mute) begin
        @(posedge clk);
        #1 busy_tx = 1'b1;
        repeat (FRAME - 1) @(posedge clk);
        #1 busy_tx = 1'b0;
      end
    end
  end

  // Requester lanes: hold the head byte until acked, then present the next one.
  initial begin
    req  = '0;
    last = '0;
    data = '0;
    forever begin
      @(negedge clk);
      ack_s = ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ack_s[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
        if (stim_q[i].size() > 0) begin
          req[i]          = 1'b1;
          last[i]         = stim_q[i][0][8];
          data[8*i +: 8]  = stim_q[i][0][7:0];
        end else begin
          req[i]  = 1'b0;
          last[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every transmit must match the next expected (lane, byte).
  initial begin
    forever begin
      @(negedge clk);
      if (nRst && transmit) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected: got byte 0x%0h grant 0x%0h, expected no transmit",
                   data_tx, grant);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_data", data_tx, mon_e[7:0]);
          chk("tx_ack", ack, 4'b0001 << mon_e[9:8]);
          chk("tx_grant", grant, 4'b0001 << mon_e[9:8]);
        end
      end else if (ack != '0) begin
        chk("ack_without_transmit", ack, 4'b0000);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRst = 1'b0;
    repeat (2) step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_transmit", transmit, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_data_tx", data_tx, 8'h00);
    nRst = 1'b1;
    step();

    // Two-byte message from lane 0.
    send(0, 1'b0, 8'h32);
    send(0, 1'b1, 8'h0A);
    expect_tx(2'd0, 8'h32);
    expect_tx(2'd0, 8'h0A);
    wait_exp(0, "t1");
    wait_busy(1'b1, "t1");
    wait_busy(1'b0, "t1");
    chk("t1_grant_at_busy_fall", grant, 4'b0001);
    step();
    chk("t1_grant_released", grant, 4'b0000);

    // From reset: 0 and 2 (and 3) pending, 0 re-asserts right after its ack.
    nRst = 1'b0;
    send(0, 1'b1, 8'hA0);
    send(0, 1'b1, 8'hA1);
    send(2, 1'b1, 8'hC2);
    send(3, 1'b1, 8'hD3);
    expect_tx(2'd0, 8'hA0);
    expect_tx(2'd2, 8'hC2);
    expect_tx(2'd3, 8'hD3);
    expect_tx(2'd0, 8'hA1);
    repeat (2) step();
    nRst = 1'b1;
    drain("t2");

    // Lane 1 three-byte message must not be interleaved with lane 3 (ptr is 1).
    send(1, 1'b0, 8'h11);
    send(1, 1'b0, 8'h12);
    send(1, 1'b1, 8'h13);
    send(3, 1'b1, 8'h33);
    expect_tx(2'd1, 8'h11);
    expect_tx(2'd1, 8'h12);
    expect_tx(2'd1, 8'h13);
    expect_tx(2'd3, 8'h33);
    drain("t3");

    // Lane 1 stalls mid-message (ptr is 0); lane 2 waits behind the lock.
    send(1, 1'b0, 8'h51);
    send(2, 1'b1, 8'h62);
    expect_tx(2'd1, 8'h51);
    expect_tx(2'd2, 8'h62);
    wait_exp(1, "t4");
    wait_busy(1'b1, "t4");
    wait_busy(1'b0, "t4");
    tmo_at  = -1;
    tmo_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 16) chk("t4_grant_held", grant, 4'b0010);
      if (timeout_err) begin
        tmo_cnt++;
        if (tmo_at < 0) begin
          tmo_at = n;
          chk("t4_grant_at_timeout", grant, 4'b0000);
        end
      end
    end
    chk("t4_timeout_cycle", tmo_at, 17);
    chk("t4_timeout_pulses", tmo_cnt, 1);
    chk("t4_drained", exp_q.size(), 0);

    // No busy_tx at all: start-wait expires and arbitration continues (ptr is 3).
    uart_mute = 1'b1;
    send(0, 1'b1, 8'h77);
    send(1, 1'b1, 8'h78);
    expect_tx(2'd0, 8'h77);
    expect_tx(2'd1, 8'h78);
    wait_exp(1, "t5");
    tx_at = -1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n == 8) chk("t5_grant_waiting", grant, 4'b0001);
      if (n == 9) chk("t5_grant_released", grant, 4'b0000);
      if (transmit && tx_at < 0) tx_at = n;
    end
    chk("t5_next_transmit", tx_at, 10);
    repeat (10) step();
    chk("t5_drained", exp_q.size(), 0);
    uart_mute = 1'b0;

    // Reset during WAIT_DONE of lane 2's first byte (ptr is 2).
    send(2, 1'b0, 8'h91);
    send(2, 1'b1, 8'h92);
    expect_tx(2'd2, 8'h91);
    wait_exp(0, "t6");
    wait_busy(1'b1, "t6");
    repeat (2) step();
    nRst = 1'b0;
    #1;
    chk("t6_rst_grant", grant, 4'b0000);
    chk("t6_rst_ack", ack, 4'b0000);
    chk("t6_rst_transmit", transmit, 1'b0);
    chk("t6_rst_timeout_err", timeout_err, 1'b0);
    chk("t6_rst_data_tx", data_tx, 8'h00);
    send(1, 1'b1, 8'h81);
    send(3, 1'b1, 8'hB3);
    expect_tx(2'd1, 8'h81);
    expect_tx(2'd2, 8'h92);
    expect_tx(2'd3, 8'hB3);
    repeat (2) step();
    nRst = 1'b1;
    drain("t6");

    chk("all_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
